// File: rtl/core_pkg.sv
// Shared definitions for the core pipeline control: FSM states, forwarding selects.
package core_pkg;

   localparam int REG_W = 5;

   typedef enum logic [1:0] {
      ST_RUN  = 2'd0,
      ST_WAIT = 2'd1,
      ST_ERR  = 2'd2
   } state_t;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_MEM = 2'b01;
   localparam logic [1:0] FWD_WB  = 2'b10;

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_unit.sv
// Forwarding comparator for one EX operand; MEM result wins over WB, x0 never forwarded.
module fwd_unit
   import core_pkg::*;
(
   input  logic [REG_W-1:0] ex_rs,
   input  logic [REG_W-1:0] me_rd,
   input  logic             me_regs_write,
   input  logic [REG_W-1:0] wb_rd,
   input  logic             wb_regs_write,
   output logic [1:0]       fwd_sel
);

   // youngest producer first
   always_comb begin
      fwd_sel = FWD_RF;
      if (me_regs_write && (me_rd != '0) && (me_rd == ex_rs))
         fwd_sel = FWD_MEM;
      else if (wb_regs_write && (wb_rd != '0) && (wb_rd == ex_rs))
         fwd_sel = FWD_WB;
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush/forwarding control for the 5-stage core with memory-wait timeout supervision.
module pipe_hazard_ctrl
   import core_pkg::*;
#(
   parameter int MEM_TIMEOUT = 15,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [REG_W-1:0] id_rs1,
   input  logic [REG_W-1:0] id_rs2,
   input  logic             id_use_rs1,
   input  logic             id_use_rs2,
   input  logic [REG_W-1:0] ex_rs1,
   input  logic [REG_W-1:0] ex_rs2,
   input  logic [REG_W-1:0] ex_rd,
   input  logic             ex_mem2reg,
   input  logic             ex_branch_taken,
   input  logic [REG_W-1:0] me_rd,
   input  logic             me_regs_write,
   input  logic             me_mem_req,
   input  logic             me_mem_ready,
   input  logic [REG_W-1:0] wb_rd,
   input  logic             wb_regs_write,
   output logic             pc_en,
   output logic             if_id_en,
   output logic             id_ex_en,
   output logic             ex_mem_en,
   output logic             mem_wb_en,
   output logic             if_id_flush,
   output logic             id_ex_flush,
   output logic             mem_wb_flush,
   output logic [1:0]       fwd_a_sel,
   output logic [1:0]       fwd_b_sel,
   output logic             mem_err,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

   state_t                      state;
   logic [7:0]                  wait_cnt;
   logic                        mem_stall;
   logic                        load_use;
   logic                        br_flush;
   logic [1:0][REG_W-1:0]       ex_rs_v;
   logic [1:0][1:0]             fwd_raw;

   assign ex_rs_v = {ex_rs2, ex_rs1};

   genvar g;
   generate
      for (g = 0; g < 2; g++) begin : g_fwd
         fwd_unit u_fwd (
            .ex_rs         (ex_rs_v[g]),
            .me_rd         (me_rd),
            .me_regs_write (me_regs_write),
            .wb_rd         (wb_rd),
            .wb_regs_write (wb_regs_write),
            .fwd_sel       (fwd_raw[g])
         );
      end
   endgenerate

   // hazard detection and enable/flush/forward selection, priority mem > branch > load-use
   always_comb begin
      mem_stall    = me_mem_req && !me_mem_ready && (state != ST_ERR);
      load_use     = ex_mem2reg && (ex_rd != '0) &&
                     ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));
      pc_en        = 1'b1;
      if_id_en     = 1'b1;
      id_ex_en     = 1'b1;
      ex_mem_en    = 1'b1;
      mem_wb_en    = 1'b1;
      if_id_flush  = 1'b0;
      id_ex_flush  = 1'b0;
      mem_wb_flush = 1'b0;
      br_flush     = 1'b0;
      fwd_a_sel    = fwd_raw[0];
      fwd_b_sel    = fwd_raw[1];
      if (rst) begin
         // reset reads as idle RUN regardless of pipeline inputs
         fwd_a_sel = FWD_RF;
         fwd_b_sel = FWD_RF;
      end else if (state == ST_ERR) begin
         pc_en     = 1'b0;
         if_id_en  = 1'b0;
         id_ex_en  = 1'b0;
         ex_mem_en = 1'b0;
         mem_wb_en = 1'b0;
         fwd_a_sel = FWD_RF;
         fwd_b_sel = FWD_RF;
      end else if (mem_stall) begin
         // MEM/WB gets a bubble so the stalled instruction does not write back twice
         pc_en        = 1'b0;
         if_id_en     = 1'b0;
         id_ex_en     = 1'b0;
         ex_mem_en    = 1'b0;
         mem_wb_flush = 1'b1;
      end else if (ex_branch_taken) begin
         if_id_flush = 1'b1;
         id_ex_flush = 1'b1;
         br_flush    = 1'b1;
      end else if (load_use) begin
         pc_en       = 1'b0;
         if_id_en    = 1'b0;
         id_ex_flush = 1'b1;
      end
   end

   // memory-wait supervision FSM with sticky timeout error
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_RUN;
         wait_cnt <= '0;
         mem_err  <= 1'b0;
      end else begin
         case (state)
            ST_RUN: begin
               if (mem_stall) begin
                  state    <= ST_WAIT;
                  wait_cnt <= 8'd1;
               end
            end
            ST_WAIT: begin
               if (me_mem_ready) begin
                  state    <= ST_RUN;
                  wait_cnt <= '0;
               end else if (wait_cnt == TIMEOUT) begin
                  state   <= ST_ERR;
                  mem_err <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + 8'd1;
               end
            end
            default: state <= ST_ERR;
         endcase
      end
   end

   // saturating stall/flush performance counters
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (!pc_en && (state != ST_ERR) && (stall_cnt != '1))
            stall_cnt <= stall_cnt + 1'b1;
         if (br_flush && (flush_cnt != '1))
            flush_cnt <= flush_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench: stimulus queues hand-computed expectations, a negedge monitor checks them.
module tb_pipe_hazard_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, me_rd, wb_rd;
   logic       id_use_rs1, id_use_rs2, ex_mem2reg, ex_branch_taken;
   logic       me_regs_write, me_mem_req, me_mem_ready, wb_regs_write;
   logic       pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
   logic       if_id_flush, id_ex_flush, mem_wb_flush, mem_err;
   logic [1:0] fwd_a_sel, fwd_b_sel;
   logic [3:0] stall_cnt, flush_cnt;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string      name;
      logic [4:0] en;   // {pc, if_id, id_ex, ex_mem, mem_wb}
      logic [2:0] fl;   // {if_id, id_ex, mem_wb}
      logic [1:0] fa;
      logic [1:0] fb;
      logic       err;
      int         sc;
      int         fc;
   } exp_t;

   exp_t q[$];

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(4)) dut (
      .clk(clk), .rst(rst),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
      .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_mem2reg(ex_mem2reg),
      .ex_branch_taken(ex_branch_taken),
      .me_rd(me_rd), .me_regs_write(me_regs_write), .me_mem_req(me_mem_req),
      .me_mem_ready(me_mem_ready),
      .wb_rd(wb_rd), .wb_regs_write(wb_regs_write),
      .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en),
      .mem_wb_en(mem_wb_en),
      .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .mem_wb_flush(mem_wb_flush),
      .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
      .mem_err(mem_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s.%s: got %0h expected %0h", nm, fld, act, exp);
      end
   endtask

   // monitor: outputs are sampled mid-cycle, away from the active edge
   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         chk(e.name, "en", 32'({pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en}), 32'(e.en));
         chk(e.name, "flush", 32'({if_id_flush, id_ex_flush, mem_wb_flush}), 32'(e.fl));
         chk(e.name, "fwd_a", 32'(fwd_a_sel), 32'(e.fa));
         chk(e.name, "fwd_b", 32'(fwd_b_sel), 32'(e.fb));
         chk(e.name, "mem_err", 32'(mem_err), 32'(e.err));
         chk(e.name, "stall_cnt", 32'(stall_cnt), 32'(e.sc));
         chk(e.name, "flush_cnt", 32'(flush_cnt), 32'(e.fc));
      end
   end

   task automatic step(input string nm, input logic [4:0] en, input logic [2:0] fl,
                       input logic [1:0] fa, input logic [1:0] fb, input logic err,
                       input int sc, input int fc);
      exp_t e;
      e.name = nm; e.en = en; e.fl = fl; e.fa = fa; e.fb = fb; e.err = err; e.sc = sc; e.fc = fc;
      q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic clr_in();
      id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
      ex_rs1 = 0; ex_rs2 = 0; ex_rd = 0; ex_mem2reg = 0; ex_branch_taken = 0;
      me_rd = 0; me_regs_write = 0; me_mem_req = 0; me_mem_ready = 0;
      wb_rd = 0; wb_regs_write = 0;
   endtask

   task automatic load_use_rs1();
      ex_mem2reg = 1; ex_rd = 5; id_rs1 = 5; id_use_rs1 = 1;
   endtask

   // reset is checked while still asserted, after the first reset edge
   task automatic do_reset();
      rst = 1;
      @(posedge clk);
      #1;
      step("reset", 5'b11111, 3'b000, 2'b00, 2'b00, 1'b0, 0, 0);
      rst = 0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      clr_in();
      do_reset();

      // load-use hazard: exactly one bubble
      load_use_rs1();
      step("lu_rs1", 5'b00111, 3'b010, 2'b00, 2'b00, 1'b0, 0, 0);
      clr_in();
      step("lu_after", 5'b11111, 3'b000, 2'b00, 2'b00, 1'b0, 1, 0);
      ex_mem2reg = 1; ex_rd = 0; id_rs1 = 0; id_use_rs1 = 1;
      step("lu_x0", 5'b11111, 3'b000, 2'b00, 2'b00, 1'b0, 1, 0);
      ex_mem2reg = 1; ex_rd = 5; id_rs1 = 5; id_use_rs1 = 0;
      step("lu_unused", 5'b11111, 3'b000, 2'b00, 2'b00, 1'b0, 1, 0);
      clr_in();
      ex_mem2reg = 1; ex_rd = 9; id_rs2 = 9; id_use_rs2 = 1;
      step("lu_rs2", 5'b00111, 3'b010, 2'b00, 2'b00, 1'b0, 1, 0);
      clr_in();
      step("lu_rs2_after", 5'b11111, 3'b000, 2'b00, 2'b00, 1'b0, 2, 0);

      // branch beats load-use
      load_use_rs1();
      ex_branch_taken = 1;
      step("br_lu", 5'b11111, 3'b110, 2'b00, 2'b00, 1'b0, 2, 0);
      clr_in();
      step("br_after", 5'b11111, 3'b000, 2'b00, 2'b00, 1'b0, 2, 1);

      // memory wait of 3 cycles; first cycle also has branch+load-use pending
      me_mem_req = 1; me_mem_ready = 0;
      load_use_rs1();
      ex_branch_taken = 1;
      step("mw1", 5'b00001, 3'b001, 2'b00, 2'b00, 1'b0, 2, 1);
      clr_in();
      me_mem_req = 1; me_mem_ready = 0;
      step("mw2", 5'b00001, 3'b001, 2'b00, 2'b00, 1'b0, 3, 1);
      step("mw3", 5'b00001, 3'b001, 2'b00, 2'b00, 1'b0, 4, 1);
      me_mem_ready = 1;
      step("mw_ready", 5'b11111, 3'b000, 2'b00, 2'b00, 1'b0, 5, 1);
      step("mw_ready_now", 5'b11111, 3'b000, 2'b00, 2'b00, 1'b0, 5, 1);
      clr_in();
      step("mw_idle", 5'b11111, 3'b000, 2'b00, 2'b00, 1'b0, 5, 1);

      // forwarding
      ex_rs1 = 7; ex_rs2 = 9; me_rd = 7; me_regs_write = 1; wb_rd = 9; wb_regs_write = 1;
      step("fwd_mem_wb", 5'b11111, 3'b000, 2'b01, 2'b10, 1'b0, 5, 1);
      ex_rs1 = 7; ex_rs2 = 3; me_rd = 7; wb_rd = 7;
      step("fwd_prio", 5'b11111, 3'b000, 2'b01, 2'b00, 1'b0, 5, 1);
      ex_rs1 = 0; ex_rs2 = 0; me_rd = 0; wb_rd = 0;
      step("fwd_x0", 5'b11111, 3'b000, 2'b00, 2'b00, 1'b0, 5, 1);
      ex_rs1 = 7; ex_rs2 = 7; me_rd = 7; me_regs_write = 0; wb_rd = 7;
      step("fwd_wb_only", 5'b11111, 3'b000, 2'b10, 2'b10, 1'b0, 5, 1);
      clr_in();

      // reset in the middle of a memory wait
      me_mem_req = 1; me_mem_ready = 0;
      step("mid_w0", 5'b00001, 3'b001, 2'b00, 2'b00, 1'b0, 5, 1);
      step("mid_w1", 5'b00001, 3'b001, 2'b00, 2'b00, 1'b0, 6, 1);
      do_reset();
      clr_in();
      step("mid_post", 5'b11111, 3'b000, 2'b00, 2'b00, 1'b0, 0, 0);

      // stall counter saturates at 15 with a 4-bit counter
      load_use_rs1();
      for (int i = 0; i < 20; i++)
         step($sformatf("sat%0d", i), 5'b00111, 3'b010, 2'b00, 2'b00, 1'b0, (i > 15) ? 15 : i, 0);
      clr_in();
      step("sat_end", 5'b11111, 3'b000, 2'b00, 2'b00, 1'b0, 15, 0);

      // timeout: 4 WAIT cycles then ERR
      do_reset();
      me_mem_req = 1; me_mem_ready = 0;
      step("to_run", 5'b00001, 3'b001, 2'b00, 2'b00, 1'b0, 0, 0);
      step("to_w1", 5'b00001, 3'b001, 2'b00, 2'b00, 1'b0, 1, 0);
      step("to_w2", 5'b00001, 3'b001, 2'b00, 2'b00, 1'b0, 2, 0);
      step("to_w3", 5'b00001, 3'b001, 2'b00, 2'b00, 1'b0, 3, 0);
      step("to_w4", 5'b00001, 3'b001, 2'b00, 2'b00, 1'b0, 4, 0);
      ex_rs1 = 7; me_rd = 7; me_regs_write = 1; ex_branch_taken = 1;
      step("err1", 5'b00000, 3'b000, 2'b00, 2'b00, 1'b1, 5, 0);
      me_mem_ready = 1;
      step("err2", 5'b00000, 3'b000, 2'b00, 2'b00, 1'b1, 5, 0);
      do_reset();
      clr_in();
      step("err_post", 5'b11111, 3'b000, 2'b00, 2'b00, 1'b0, 0, 0);

      // every queued expectation must have been consumed
      for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expectations left, required 0", q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
